fetch_ctrl: RTL and testbench

Fetch-side sequencer for the five-stage pipeline. It drives the PC register enable, the IF/ID register enable, the PC-select mux and the pipeline flushes. It arbitrates between branch/jump redirects, load-use stalls and instruction-cache misses. On a miss it runs the refill handshake toward memory and holds any redirect that arrives during the refill until fetch resumes.

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch sequencer.
// State encoding and PC mux select codes.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } fetch_state_e;

    localparam logic [1:0] PCSRC_SEQ   = 2'd0;
    localparam logic [1:0] PCSRC_REDIR = 2'd1;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-side sequencer: PC/IF-ID enables, PC select, flushes,
// and the I-cache refill handshake with held redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hit_i,
    input  logic             lw_stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirTarget_i,
    input  logic             refill_ack_i,
    input  logic             refill_valid_i,
    output logic             PCEn_o,
    output logic [1:0]       PCsrc_o,
    output logic [31:0]      redirTarget_o,
    output logic             IF_ID_En_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic             refill_req_o,
    output logic             refill_we_o,
    output logic [IDX_W-1:0] refill_idx_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    fetch_state_e     state_q, state_d;
    logic             pend_q, pend_d;
    logic [31:0]      pendTarget_q, pendTarget_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            pend_q       <= 1'b0;
            pendTarget_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pendTarget_q <= pendTarget_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        pendTarget_d  = pendTarget_q;
        cnt_d         = cnt_q;
        PCEn_o        = 1'b0;
        PCsrc_o       = PCSRC_SEQ;
        redirTarget_o = redirTarget_i;
        IF_ID_En_o    = 1'b1;
        IF_ID_flush_o = 1'b0;
        ID_EX_flush_o = 1'b0;
        refill_req_o  = 1'b0;
        refill_we_o   = 1'b0;
        refill_idx_o  = '0;

        unique case (state_q)
            RUN: begin
                if (pend_q) begin
                    PCEn_o        = 1'b1;
                    PCsrc_o       = PCSRC_REDIR;
                    redirTarget_o = pendTarget_q;
                    IF_ID_flush_o = 1'b1;
                    pend_d        = 1'b0;
                end else if (redirect_i) begin
                    PCEn_o        = 1'b1;
                    PCsrc_o       = PCSRC_REDIR;
                    IF_ID_flush_o = 1'b1;
                    ID_EX_flush_o = 1'b1;
                end else if (lw_stall_i) begin
                    IF_ID_En_o    = 1'b0;
                    ID_EX_flush_o = 1'b1;
                end else if (!hit_i) begin
                    IF_ID_flush_o = 1'b1;
                    state_d       = REQ;
                    cnt_d         = '0;
                end else begin
                    PCEn_o = 1'b1;
                end
            end
            REQ, DATA: begin
                IF_ID_En_o    = !lw_stall_i;
                IF_ID_flush_o = 1'b1;
                ID_EX_flush_o = redirect_i | lw_stall_i;
                // Redirects during a refill are parked, never abort it
                if (redirect_i) begin
                    pend_d       = 1'b1;
                    pendTarget_d = redirTarget_i;
                end
                if (state_q == REQ) begin
                    refill_req_o = 1'b1;
                    if (refill_ack_i) state_d = DATA;
                end else begin
                    refill_we_o  = refill_valid_i;
                    refill_idx_o = cnt_q;
                    if (refill_valid_i) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        if (rst_i) begin
            PCEn_o        = 1'b0;
            PCsrc_o       = PCSRC_SEQ;
            IF_ID_En_o    = 1'b0;
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
            refill_req_o  = 1'b0;
            refill_we_o   = 1'b0;
            refill_idx_o  = '0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed + random checks of fetch_ctrl against a behavioural
// model of the fetch/refill protocol.
module tb_fetch_ctrl;
    localparam int LW = 4;
    localparam int IW = $clog2(LW);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          hit_i, lw_stall_i, redirect_i;
    logic [31:0]   redirTarget_i;
    logic          refill_ack_i, refill_valid_i;
    logic          PCEn_o, IF_ID_En_o, IF_ID_flush_o, ID_EX_flush_o;
    logic [1:0]    PCsrc_o;
    logic [31:0]   redirTarget_o;
    logic          refill_req_o, refill_we_o;
    logic [IW-1:0] refill_idx_o;

    fetch_ctrl #(.LINE_WORDS(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hit_i(hit_i),
        .lw_stall_i(lw_stall_i), .redirect_i(redirect_i),
        .redirTarget_i(redirTarget_i), .refill_ack_i(refill_ack_i),
        .refill_valid_i(refill_valid_i), .PCEn_o(PCEn_o),
        .PCsrc_o(PCsrc_o), .redirTarget_o(redirTarget_o),
        .IF_ID_En_o(IF_ID_En_o), .IF_ID_flush_o(IF_ID_flush_o),
        .ID_EX_flush_o(ID_EX_flush_o), .refill_req_o(refill_req_o),
        .refill_we_o(refill_we_o), .refill_idx_o(refill_idx_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    // Reference model: refilling flag, ack seen, beats delivered,
    // and the most recent parked redirect.
    bit          refilling, acked, held, just_done;
    int          beats;
    logic [31:0] held_tgt;

    task automatic model_check();
        logic        e_pcen, e_en, e_fl, e_idex, e_req, e_we;
        logic [1:0]  e_src;
        logic [31:0] e_tgt;
        int          e_idx;
        e_pcen = 0; e_en = 1; e_fl = 0; e_idex = 0;
        e_req = 0; e_we = 0; e_src = 0; e_tgt = redirTarget_i; e_idx = 0;
        if (!refilling) begin
            if (held) begin
                e_pcen = 1; e_src = 1; e_tgt = held_tgt; e_fl = 1;
            end else if (redirect_i) begin
                e_pcen = 1; e_src = 1; e_fl = 1; e_idex = 1;
            end else if (lw_stall_i) begin
                e_en = 0; e_idex = 1;
            end else if (!hit_i) begin
                e_fl = 1;
            end else begin
                e_pcen = 1;
            end
        end else begin
            e_en = !lw_stall_i; e_fl = 1;
            e_idex = redirect_i | lw_stall_i;
            e_req = !acked;
            e_we = acked & refill_valid_i;
            e_idx = acked ? beats : 0;
        end
        chk("PCEn", 32'(PCEn_o), 32'(e_pcen));
        chk("PCsrc", 32'(PCsrc_o), 32'(e_src));
        chk("redirTarget", redirTarget_o, e_tgt);
        chk("IF_ID_En", 32'(IF_ID_En_o), 32'(e_en));
        chk("IF_ID_flush", 32'(IF_ID_flush_o), 32'(e_fl));
        chk("ID_EX_flush", 32'(ID_EX_flush_o), 32'(e_idex));
        chk("refill_req", 32'(refill_req_o), 32'(e_req));
        chk("refill_we", 32'(refill_we_o), 32'(e_we));
        chk("refill_idx", 32'(refill_idx_o), 32'(e_idx));
    endtask

    task automatic model_step();
        just_done = 0;
        if (!refilling) begin
            if (held) held = 0;
            else if (!redirect_i && !lw_stall_i && !hit_i) begin
                refilling = 1; acked = 0; beats = 0;
            end
        end else begin
            if (redirect_i) begin
                held = 1; held_tgt = redirTarget_i;
            end
            if (!acked) acked = refill_ack_i;
            else if (refill_valid_i) begin
                beats++;
                if (beats == LW) begin
                    refilling = 0; just_done = 1;
                end
            end
        end
    endtask

    task automatic step(input logic h, input logic l, input logic r,
                        input logic [31:0] t, input logic a,
                        input logic v);
        @(negedge clk_i);
        hit_i = h; lw_stall_i = l; redirect_i = r;
        redirTarget_i = t; refill_ack_i = a; refill_valid_i = v;
        #1;
        model_check();
        @(posedge clk_i);
        model_step();
    endtask

    task automatic reset_pulse();
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_PCEn", 32'(PCEn_o), 32'd0);
        chk("rst_IF_ID_En", 32'(IF_ID_En_o), 32'd0);
        chk("rst_IF_ID_flush", 32'(IF_ID_flush_o), 32'd1);
        chk("rst_ID_EX_flush", 32'(ID_EX_flush_o), 32'd1);
        chk("rst_refill_req", 32'(refill_req_o), 32'd0);
        chk("rst_refill_we", 32'(refill_we_o), 32'd0);
        chk("rst_PCsrc", 32'(PCsrc_o), 32'd0);
        chk("rst_refill_idx", 32'(refill_idx_o), 32'd0);
        refilling = 0; acked = 0; held = 0; beats = 0; just_done = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        hit_i = 1; lw_stall_i = 0; redirect_i = 0; redirTarget_i = 0;
        refill_ack_i = 0; refill_valid_i = 0;
        refilling = 0; acked = 0; held = 0; beats = 0; just_done = 0;
        held_tgt = 0;
        reset_pulse();

        repeat (10) step(1, 0, 0, 32'h0, 0, 0);

        step(0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1);
        step(1, 0, 1, 32'h100, 0, 1);
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 1);
        step(1, 0, 0, 32'h0, 0, 1);
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);

        step(1, 1, 1, 32'h200, 0, 0);

        step(0, 0, 0, 32'h0, 0, 0);
        step(1, 1, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1);
        step(1, 0, 0, 32'h0, 0, 1);
        reset_pulse();
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic h, l, r, a, v;
            h = just_done ? 1'b1 : ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) < 2);
            r = ($urandom_range(0, 9) < 2);
            a = ($urandom_range(0, 9) < 4);
            v = refilling && acked && ($urandom_range(0, 9) < 7);
            step(h, l, r, $urandom, a, v);
            if (i == 250) reset_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
